// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage, its IF/ID latch and its bus interface.
//   NOP_INSTR        : instruction injected into IF/ID on reset and flush (ARM MOV r0,r0 class)
//   ADDR_W_DEF       : default PC / address width
//   INSTR_W_DEF      : default instruction width
//   PC_STEP_DEF      : default byte increment per sequential fetch
//   fetch_op_e       : action the fetch stage takes on a clock edge
//   fetch_op()       : resolves rst/branch_taken/freeze into a single fetch_op_e by priority
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned INSTR_W_DEF = 32;
    localparam int unsigned PC_STEP_DEF = 4;

    localparam logic [31:0] NOP_INSTR = 32'hE000_0000;

    typedef enum logic [1:0] {
        OpReset,
        OpRedirect,
        OpHold,
        OpAdvance
    } fetch_op_e;

    // Redirect beats stall: a taken branch must never be lost behind a freeze.
    function automatic fetch_op_e fetch_op(input logic rst, input logic branch_taken,
                                           input logic freeze);
        if (rst) begin
            return OpReset;
        end else if (branch_taken) begin
            return OpRedirect;
        end else if (freeze) begin
            return OpHold;
        end
        return OpAdvance;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its neighbours (hazard unit, EX, instruction memory, decode).
//   freeze, branch_taken, branch_addr : control into fetch
//   imem_addr / imem_data             : combinational instruction-memory read
//   id_pc, id_instr, id_valid         : IF/ID latch contents read by decode
// Modports: master = fetch stage side, slave = surrounding pipeline side.
interface fetch_stage_if
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
) ();

    logic               freeze;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_addr;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [ADDR_W-1:0]  id_pc;
    logic [INSTR_W-1:0] id_instr;
    logic               id_valid;

    modport master (
        input  freeze, branch_taken, branch_addr, imem_data,
        output imem_addr, id_pc, id_instr, id_valid
    );

    modport slave (
        output freeze, branch_taken, branch_addr, imem_data,
        input  imem_addr, id_pc, id_instr, id_valid
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : taken branch; inserts a bubble (beats freeze)
//   freeze          : hold current contents
//   d_pc, d_instr   : pc+step and instruction of the word being fetched
//   id_pc, id_instr, id_valid : registered outputs to decode
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               freeze,
    input  logic [ADDR_W-1:0]  d_pc,
    input  logic [INSTR_W-1:0] d_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic               id_valid
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            id_pc    <= '0;
            id_instr <= INSTR_W'(NOP_INSTR);
            id_valid <= 1'b0;
        end else if (!freeze) begin
            id_pc    <= d_pc;
            id_instr <= d_instr;
            id_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address combinationally
// and registers {pc+PC_STEP, instruction, valid} into the IF/ID latch.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_stage_if.master (freeze/redirect in, imem read, IF/ID out)
//   stall_cnt, flush_cnt : saturating event counters, present only when PERF_CNT_EN is defined
// Optional feature macro: PERF_CNT_EN.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       INSTR_W  = INSTR_W_DEF,
    parameter int unsigned       PC_STEP  = PC_STEP_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef PERF_CNT_EN
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt,
`endif
    fetch_stage_if.master        bus
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_seq;
    fetch_op_e         op;

    // Sequential increment wraps modulo 2^ADDR_W by truncation.
    always_comb begin
        pc_seq = pc_q + ADDR_W'(PC_STEP);
        op     = fetch_op(rst, bus.branch_taken, bus.freeze);
        pc_d   = pc_q;
        unique case (op)
            OpReset:    pc_d = RESET_PC;
            OpRedirect: pc_d = bus.branch_addr;
            OpHold:     pc_d = pc_q;
            OpAdvance:  pc_d = pc_seq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.imem_addr = pc_q;

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.branch_taken),
        .freeze   (bus.freeze),
        .d_pc     (pc_seq),
        .d_instr  (bus.imem_data),
        .id_pc    (bus.id_pc),
        .id_instr (bus.id_instr),
        .id_valid (bus.id_valid)
    );

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // A freeze that coincides with a redirect is counted as a flush only.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.freeze && !bus.branch_taken && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (bus.branch_taken && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic clk;
    logic rst;

    fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) bus ();
    fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) wbus ();

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, w_stall_cnt, w_flush_cnt;
`endif

    fetch_stage #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .PC_STEP  (4),
        .RESET_PC (32'h0)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PERF_CNT_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .bus       (bus)
    );

    fetch_stage #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .PC_STEP  (4),
        .RESET_PC (32'hFFFF_FFFC)
    ) u_wrap (
        .clk       (clk),
        .rst       (rst),
`ifdef PERF_CNT_EN
        .stall_cnt (w_stall_cnt),
        .flush_cnt (w_flush_cnt),
`endif
        .bus       (wbus)
    );

    // Instruction memory contents: a fixed address scramble, never equal to NOP for test addresses.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    assign bus.imem_data  = imem(bus.imem_addr);
    assign wbus.imem_data = imem(wbus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [31:0] m_pc, m_id_pc, m_id_instr;
    logic        m_id_valid;
    logic [31:0] m_stall, m_flush;

    task automatic model_step();
        if (rst) begin
            m_pc       = 32'h0;
            m_id_pc    = 32'h0;
            m_id_instr = NOP_INSTR;
            m_id_valid = 1'b0;
            m_stall    = 32'h0;
            m_flush    = 32'h0;
        end else if (bus.branch_taken) begin
            m_pc       = bus.branch_addr;
            m_id_pc    = 32'h0;
            m_id_instr = NOP_INSTR;
            m_id_valid = 1'b0;
            if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
        end else if (bus.freeze) begin
            if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        end else begin
            m_id_pc    = m_pc + 32'd4;
            m_id_instr = imem(m_pc);
            m_id_valid = 1'b1;
            m_pc       = m_pc + 32'd4;
        end
    endtask

    // One clock: model follows the inputs present at the edge; outputs sampled 1 after it.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check("cyc imem_addr", bus.imem_addr, m_pc);
            check("cyc id_pc", bus.id_pc, m_id_pc);
            check("cyc id_instr", bus.id_instr, m_id_instr);
            check("cyc id_valid", {31'b0, bus.id_valid}, {31'b0, m_id_valid});
`ifdef PERF_CNT_EN
            check("cyc stall_cnt", stall_cnt, m_stall);
            check("cyc flush_cnt", flush_cnt, m_flush);
`endif
        end
    end

    initial begin
        rst               = 1'b1;
        bus.freeze        = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_addr   = 32'h0;
        wbus.freeze       = 1'b0;
        wbus.branch_taken = 1'b0;
        wbus.branch_addr  = 32'h0;

        // 1: reset then free-running fetch
        tick();
        checking = 1'b1;
        rst = 1'b0;
        check("t1 rst imem_addr", bus.imem_addr, 32'h0);
        check("t1 rst id_valid", {31'b0, bus.id_valid}, 32'h0);
        check("t1 rst id_instr", bus.id_instr, 32'hE000_0000);
        check("t1 rst id_pc", bus.id_pc, 32'h0);
        check("t5 rst imem_addr", wbus.imem_addr, 32'hFFFF_FFFC);
        tick();
        // 5: wrap of the PC from the top of the address space
        check("t5 imem_addr wrap", wbus.imem_addr, 32'h0);
        check("t5 id_pc wrap", wbus.id_pc, 32'h0);
        check("t5 id_valid", {31'b0, wbus.id_valid}, 32'h1);
        check("t5 id_instr", wbus.id_instr, imem(32'hFFFF_FFFC));
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) tick();
            check("t1 imem_addr", bus.imem_addr, 32'(4 * k));
            check("t1 id_pc", bus.id_pc, 32'(4 * k));
            check("t1 id_valid", {31'b0, bus.id_valid}, 32'h1);
            check("t1 id_instr", bus.id_instr, imem(32'(4 * (k - 1))));
        end

        // 2: freeze for 3 cycles at pc=8
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        bus.freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2 frozen pc", bus.imem_addr, 32'h8);
            check("t2 frozen id_pc", bus.id_pc, 32'h8);
            check("t2 frozen id_instr", bus.id_instr, imem(32'h4));
            check("t2 frozen id_valid", {31'b0, bus.id_valid}, 32'h1);
        end
        bus.freeze = 1'b0;
        tick();
        check("t2 resume pc", bus.imem_addr, 32'hC);
        check("t2 resume id_instr", bus.id_instr, imem(32'h8));

        // 3: branch at pc=0x10
        tick();
        check("t3 pre pc", bus.imem_addr, 32'h10);
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h100;
        tick();
        bus.branch_taken = 1'b0;
        check("t3 redirect pc", bus.imem_addr, 32'h100);
        check("t3 flush valid", {31'b0, bus.id_valid}, 32'h0);
        check("t3 flush instr", bus.id_instr, 32'hE000_0000);
        tick();
        check("t3 after id_pc", bus.id_pc, 32'h104);
        check("t3 after id_instr", bus.id_instr, imem(32'h100));

        // 4: branch and freeze together; branch wins
        bus.branch_taken = 1'b1;
        bus.freeze       = 1'b1;
        bus.branch_addr  = 32'h40;
        tick();
        bus.branch_taken = 1'b0;
        bus.freeze       = 1'b0;
        check("t4 pc", bus.imem_addr, 32'h40);
        check("t4 flush valid", {31'b0, bus.id_valid}, 32'h0);
        check("t4 flush instr", bus.id_instr, 32'hE000_0000);

        // 6: 2 stalls + 1 flush, then reset mid-stream at pc=0x20
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.freeze = 1'b1;
        tick();
        tick();
        bus.freeze       = 1'b0;
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h18;
        tick();
        bus.branch_taken = 1'b0;
        tick();
        tick();
        check("t6 pre-rst pc", bus.imem_addr, 32'h20);
`ifdef PERF_CNT_EN
        check("t6 stall_cnt", stall_cnt, 32'd2);
        check("t6 flush_cnt", flush_cnt, 32'd1);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6 rst pc", bus.imem_addr, 32'h0);
        check("t6 rst id_valid", {31'b0, bus.id_valid}, 32'h0);
`ifdef PERF_CNT_EN
        check("t6 rst stall_cnt", stall_cnt, 32'd0);
        check("t6 rst flush_cnt", flush_cnt, 32'd0);
`endif

        // Randomized run, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(63) == 0);
            bus.branch_taken = ($urandom_range(7) == 0);
            bus.freeze       = ($urandom_range(3) == 0);
            case ($urandom_range(3))
                0:       bus.branch_addr = $urandom;
                1:       bus.branch_addr = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                default: bus.branch_addr = 32'($urandom_range(1023)) << 2;
            endcase
            tick();
        end

        rst = 1'b0;
        bus.freeze = 1'b0;
        bus.branch_taken = 1'b0;
        @(negedge clk);
        #1;
        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
